alu_operand_queue: RTL and testbench

//  Upstream issue stage for the 18x18+48 ALU. Accepts operation requests (A,B,D,C,select,carryin,tag)

---
 rtl/alu_operand_queue.sv | 140 ++++++++++++++
 tb/tb_alu_operand_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_queue.sv
// alu_operand_queue: buffers ALU op requests in a DEPTH-entry FIFO, issues one per cycle to registered operands, flags result cycle.
// Latency: push->issue >= 1 edge; issue->res_valid ALU_LAT+1 edges. Backpressure: in_ready drops when full, flushing or in reset.
// Optional saturating issue/stall counters when OPQ_STATS_EN is defined.
module alu_operand_queue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [17:0]              in_a,
    input  logic [17:0]              in_b,
    input  logic [17:0]              in_d,
    input  logic [47:0]              in_c,
    input  logic [1:0]               in_sel,
    input  logic                     in_cin,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     issue_en,
    input  logic                     flush,
    output logic [17:0]              alu_a,
    output logic [17:0]              alu_b,
    output logic [17:0]              alu_d,
    output logic [47:0]              alu_c,
    output logic [1:0]               alu_select,
    output logic                     alu_carryin,
    output logic                     res_valid,
    output logic [TAG_W-1:0]         res_tag,
    output logic [$clog2(DEPTH):0]   level
`ifdef OPQ_STATS_EN
    ,
    output logic [15:0]              stat_issued,
    output logic [15:0]              stat_stall
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [17:0] a;
        logic [17:0] b;
        logic [17:0] d;
        logic [47:0] c;
        logic [1:0]  sel;
        logic        cin;
    } alu_op_t;

    typedef struct packed {
        alu_op_t          op;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    alu_op_t          r_alu;
    logic [ALU_LAT:0] r_pipe_vld;
    logic [TAG_W-1:0] r_pipe_tag [ALU_LAT+1];

    logic   w_full;
    logic   w_push;
    logic   w_pop;
    entry_t w_in;

    // No pass-through at full: a same-cycle pop does not free a slot for the push.
    assign w_full   = (r_level == LW'(DEPTH));
    assign in_ready = !w_full && !flush && !rst;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = issue_en && (r_level != '0) && !flush && !rst;

    assign w_in = '{op: '{a: in_a, b: in_b, d: in_d, c: in_c, sel: in_sel, cin: in_cin}, tag: in_tag};

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_level <= r_level + LW'(1);
            else if (!w_push && w_pop) r_level <= r_level - LW'(1);
        end
    end

    // Operands hold across bubbles and flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst)        r_alu <= '0;
        else if (w_pop) r_alu <= r_mem[r_rd_ptr].op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i <= ALU_LAT; i++) r_pipe_tag[i] <= '0;
        end else begin
            r_pipe_vld    <= flush ? '0 : {r_pipe_vld[ALU_LAT-1:0], w_pop};
            r_pipe_tag[0] <= w_pop ? r_mem[r_rd_ptr].tag : '0;
            for (int i = 1; i <= ALU_LAT; i++) r_pipe_tag[i] <= r_pipe_tag[i-1];
        end
    end

    assign alu_a       = r_alu.a;
    assign alu_b       = r_alu.b;
    assign alu_d       = r_alu.d;
    assign alu_c       = r_alu.c;
    assign alu_select  = r_alu.sel;
    assign alu_carryin = r_alu.cin;
    assign res_valid   = r_pipe_vld[ALU_LAT];
    assign res_tag     = r_pipe_tag[ALU_LAT];
    assign level       = r_level;

`ifdef OPQ_STATS_EN
    logic [15:0] r_stat_issued;
    logic [15:0] r_stat_stall;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_pop && (r_stat_issued != 16'hFFFF))
                r_stat_issued <= r_stat_issued + 16'd1;
            if (in_valid && !in_ready && (r_stat_stall != 16'hFFFF))
                r_stat_stall <= r_stat_stall + 16'd1;
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_alu_operand_queue.sv
// Directed self-checking bench for alu_operand_queue (DEPTH=4, TAG_W=4, ALU_LAT=1).
`timescale 1ns/1ps
module tb_alu_operand_queue;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_cin, issue_en, flush;
    logic [17:0] in_a, in_b, in_d, alu_a, alu_b, alu_d;
    logic [47:0] in_c, alu_c;
    logic [1:0]  in_sel, alu_select;
    logic        alu_carryin, res_valid;
    logic [3:0]  in_tag, res_tag;
    logic [2:0]  level;
`ifdef OPQ_STATS_EN
    logic [15:0] stat_issued, stat_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_operand_queue #(.DEPTH(4), .TAG_W(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_c(in_c), .in_sel(in_sel),
        .in_cin(in_cin), .in_tag(in_tag), .issue_en(issue_en), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d), .alu_c(alu_c),
        .alu_select(alu_select), .alu_carryin(alu_carryin),
        .res_valid(res_valid), .res_tag(res_tag), .level(level)
`ifdef OPQ_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [1:0] s, input logic [17:0] a, input logic [17:0] b,
                            input logic [17:0] d, input logic [47:0] c, input logic ci,
                            input logic [3:0] t);
        in_valid = 1'b1; in_sel = s; in_a = a; in_b = b; in_d = d; in_c = c; in_cin = ci; in_tag = t;
    endtask

    // Reference ALU: what P becomes given the registered operands.
    function automatic logic [47:0] alu_p(input logic [1:0] s, input logic [17:0] a, input logic [17:0] b,
                                          input logic [17:0] d, input logic [47:0] c, input logic ci);
        logic [47:0] aa, bb, dd;
        aa = 48'(a); bb = 48'(b); dd = 48'(d);
        case (s)
            2'b00:   return aa * bb + c;
            2'b01:   return aa * bb;
            2'b10:   return aa + dd;
            default: return (aa + dd) * bb + c + 48'(ci);
        endcase
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; issue_en = 1'b0; flush = 1'b0;
        in_a = '0; in_b = '0; in_d = '0; in_c = '0; in_sel = '0; in_cin = 1'b0; in_tag = '0;
        tick; tick;
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_tests++; if (res_valid !== 1'b0 || res_tag !== 4'd0) begin n_fail++; $display("FAIL reset_res: got v=%0b t=%0d expected v=0 t=0", res_valid, res_tag); end
        n_tests++; if ({alu_a, alu_b, alu_d, alu_c, alu_select, alu_carryin} !== '0) begin n_fail++; $display("FAIL reset_alu: got a=%0d c=%0d sel=%0d expected all 0", alu_a, alu_c, alu_select); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %0b expected 1", in_ready); end
    endtask

    task automatic test_single(input logic [1:0] s, input logic [17:0] a, input logic [17:0] b,
                               input logic [17:0] d, input logic [47:0] c, input logic ci,
                               input logic [3:0] t, input logic [47:0] exp_p);
        issue_en = 1'b1;
        drive_op(s, a, b, d, c, ci, t);
        tick;
        in_valid = 1'b0;
        n_tests++; if (level !== 3'd1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL single_residency_t%0d: got level=%0d v=%0b expected level=1 v=0", t, level, res_valid); end
        tick;
        n_tests++; if (alu_a !== a || alu_b !== b || alu_d !== d || alu_c !== c || alu_select !== s || alu_carryin !== ci) begin
            n_fail++; $display("FAIL single_operands_t%0d: got a=%0d b=%0d d=%0d c=%0d sel=%0d cin=%0b expected a=%0d b=%0d d=%0d c=%0d sel=%0d cin=%0b",
                               t, alu_a, alu_b, alu_d, alu_c, alu_select, alu_carryin, a, b, d, c, s, ci); end
        n_tests++; if (level !== 3'd0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL single_issue_t%0d: got level=%0d v=%0b expected level=0 v=0", t, level, res_valid); end
        tick;
        n_tests++; if (res_valid !== 1'b1 || res_tag !== t) begin n_fail++; $display("FAIL single_result_t%0d: got v=%0b tag=%0d expected v=1 tag=%0d", t, res_valid, res_tag, t); end
        n_tests++; if (alu_p(alu_select, alu_a, alu_b, alu_d, alu_c, alu_carryin) !== exp_p) begin
            n_fail++; $display("FAIL single_p_t%0d: got %0d expected %0d", t, alu_p(alu_select, alu_a, alu_b, alu_d, alu_c, alu_carryin), exp_p); end
        tick;
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle_t%0d: got v=%0b expected 0", t, res_valid); end
        issue_en = 1'b0;
    endtask

    task automatic test_full_backpressure;
        logic [3:0] got [8];
        int         cyc [8];
        int         n = 0;
        logic       acc;
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(2'b01, 18'(i + 1), 18'd2, 18'd0, 48'd0, 1'b0, 4'(i));
            tick;
        end
        drive_op(2'b01, 18'd5, 18'd2, 18'd0, 48'd0, 1'b0, 4'd4);
        n_tests++; if (level !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got level=%0d rdy=%0b expected level=4 rdy=0", level, in_ready); end
        tick;
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_hold: got level=%0d expected 4", level); end
        issue_en = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_passthru: got rdy=%0b expected 0", in_ready); end
        for (int c = 0; c < 12; c++) begin
            acc = in_valid && in_ready;
            tick;
            if (acc) in_valid = 1'b0;
            if (res_valid && n < 8) begin got[n] = res_tag; cyc[n] = c; n++; end
        end
        n_tests++; if (n != 5) begin n_fail++; $display("FAIL full_drain_count: got %0d expected 5", n); end
        for (int i = 0; i < 5 && i < n; i++) begin
            n_tests++; if (got[i] !== 4'(i) || cyc[i] != cyc[0] + i) begin n_fail++; $display("FAIL full_drain_order_%0d: got tag=%0d cyc=%0d expected tag=%0d cyc=%0d", i, got[i], cyc[i], i, cyc[0] + i); end
        end
        issue_en = 1'b0;
    endtask

    task automatic test_wrap;
        logic [3:0] got [16];
        int         cyc [16];
        int         n = 0;
        int         bad_level = 0;
        issue_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_op(2'b10, 18'(i), 18'd0, 18'd1, 48'd0, 1'b0, 4'(i));
            tick;
        end
        issue_en = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) drive_op(2'b10, 18'(c + 2), 18'd0, 18'd1, 48'd0, 1'b0, 4'(c + 2));
            else in_valid = 1'b0;
            tick;
            if (c < 8 && level !== 3'd2) bad_level++;
            if (res_valid && n < 16) begin got[n] = res_tag; cyc[n] = c; n++; end
        end
        n_tests++; if (bad_level != 0) begin n_fail++; $display("FAIL wrap_level: got %0d cycles with level!=2 expected 0", bad_level); end
        n_tests++; if (n != 10) begin n_fail++; $display("FAIL wrap_count: got %0d expected 10", n); end
        for (int i = 0; i < 10 && i < n; i++) begin
            n_tests++; if (got[i] !== 4'(i) || cyc[i] != cyc[0] + i) begin n_fail++; $display("FAIL wrap_order_%0d: got tag=%0d cyc=%0d expected tag=%0d cyc=%0d", i, got[i], cyc[i], i, cyc[0] + i); end
        end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL wrap_empty: got level=%0d expected 0", level); end
        issue_en = 1'b0;
    endtask

    task automatic test_flush;
        int stale = 0;
        issue_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_op(2'b00, 18'(i * 10), 18'd1, 18'd0, 48'd0, 1'b0, 4'(i));
            tick;
        end
        in_valid = 1'b0; issue_en = 1'b1;
        tick;
        n_tests++; if (level !== 3'd3 || alu_a !== 18'd10) begin n_fail++; $display("FAIL flush_setup: got level=%0d a=%0d expected level=3 a=10", level, alu_a); end
        flush = 1'b1;
        drive_op(2'b00, 18'd90, 18'd1, 18'd0, 48'd0, 1'b0, 4'd9);
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b expected 0", in_ready); end
        tick;
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (level !== 3'd0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got level=%0d v=%0b expected level=0 v=0", level, res_valid); end
        n_tests++; if (alu_a !== 18'd10) begin n_fail++; $display("FAIL flush_alu_hold: got a=%0d expected 10", alu_a); end
        for (int c = 0; c < 5; c++) begin
            tick;
            if (res_valid !== 1'b0 || level !== 3'd0) stale++;
        end
        n_tests++; if (stale != 0) begin n_fail++; $display("FAIL flush_stale: got %0d bad cycles expected 0", stale); end
        issue_en = 1'b0;
    endtask

    task automatic test_reset_midstream;
        issue_en = 1'b0;
        for (int i = 5; i <= 6; i++) begin
            drive_op(2'b11, 18'(i * 10), 18'd3, 18'd4, 48'd100, 1'b1, 4'(i));
            tick;
        end
        in_valid = 1'b0; issue_en = 1'b1;
        tick;
        n_tests++; if (alu_a !== 18'd50) begin n_fail++; $display("FAIL rst_mid_setup: got a=%0d expected 50", alu_a); end
        rst = 1'b1;
        tick;
        n_tests++; if ({alu_a, alu_b, alu_d, alu_c, alu_select, alu_carryin} !== '0) begin n_fail++; $display("FAIL rst_mid_alu: got a=%0d c=%0d sel=%0d expected all 0", alu_a, alu_c, alu_select); end
        n_tests++; if (res_valid !== 1'b0 || res_tag !== 4'd0 || level !== 3'd0) begin n_fail++; $display("FAIL rst_mid_state: got v=%0b t=%0d level=%0d expected 0 0 0", res_valid, res_tag, level); end
`ifdef OPQ_STATS_EN
        n_tests++; if (stat_issued !== 16'd0) begin n_fail++; $display("FAIL rst_mid_stat_issued: got %0d expected 0", stat_issued); end
`endif
        rst = 1'b0; issue_en = 1'b0;
        tick;
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_inflight: got v=%0b expected 0", res_valid); end
        for (int i = 0; i < 7; i++) begin
            drive_op(2'b01, 18'd1, 18'd1, 18'd0, 48'd0, 1'b0, 4'(i));
            tick;
        end
        in_valid = 1'b0;
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL rst_mid_refill: got level=%0d expected 4", level); end
`ifdef OPQ_STATS_EN
        n_tests++; if (stat_stall !== 16'd3) begin n_fail++; $display("FAIL stat_stall: got %0d expected 3", stat_stall); end
        issue_en = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        issue_en = 1'b0;
        n_tests++; if (stat_issued !== 16'd4) begin n_fail++; $display("FAIL stat_issued: got %0d expected 4", stat_issued); end
`endif
    endtask

    initial begin
        test_reset;
        test_single(2'b00, 18'd3, 18'd5, 18'd0, 48'd7, 1'b0, 4'd1, 48'd22);
        test_single(2'b11, 18'd2, 18'd4, 18'd3, 48'd10, 1'b1, 4'd2, 48'd31);
        test_full_backpressure;
        test_wrap;
        test_flush;
        test_reset_midstream;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
